// File: rtl/ram_sync_hs.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_hs
// Description : Clocked byte-addressable big-endian RAM with a MOV/MOC
//               handshake, programmable wait states and byte, half, word
//               and two-beat doubleword accesses (WordAck between beats).
//               Optional macro MISALIGN_CHK_EN: misaligned half/word/
//               doubleword requests complete at once with Err=1, no access.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sync_hs #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MOV,
  input  logic              ReadWrite,
  input  logic [1:0]        datatype,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              WordAck,
  output logic              MOC,
  output logic              Err
);

  localparam int         c_aw      = $clog2(DEPTH);
  localparam logic [3:0] c_ws_last = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BEAT0 = 3'd2,
    S_ACK   = 3'd3,
    S_BEAT1 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_start_state;
  logic            r_rw;
  logic [1:0]      r_dtype;
  logic [c_aw-1:0] r_addr;
  logic [31:0]     r_din0;
  logic [31:0]     r_din1;
  logic            r_beat1;
  logic [3:0]      r_cnt;
  logic            r_moc;
  logic            r_ack;
  logic [31:0]     r_dout;
  logic [7:0]      r_mem [DEPTH];

  logic [c_aw-1:0] w_idx0;
  logic [c_aw-1:0] w_idx1;
  logic [c_aw-1:0] w_idx2;
  logic [c_aw-1:0] w_idx3;
  logic            w_we;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_rd_data;
  logic            w_unused_addr;

  // Only the low address bits select a byte; the rest are ignored.
  assign w_unused_addr = ^Address[ADDR_W-1:c_aw];

  // Beat 1 addresses the second word; index arithmetic wraps at DEPTH.
  assign w_idx0  = r_addr + ((r_state == S_BEAT1) ? c_aw'(4) : c_aw'(0));
  assign w_idx1  = w_idx0 + c_aw'(1);
  assign w_idx2  = w_idx0 + c_aw'(2);
  assign w_idx3  = w_idx0 + c_aw'(3);
  assign w_we    = ((r_state == S_BEAT0) || (r_state == S_BEAT1)) && !r_rw;
  assign w_wdata = (r_state == S_BEAT1) ? r_din1 : r_din0;

`ifdef MISALIGN_CHK_EN
  logic w_misaligned;
  logic r_mis;
  logic r_err;

  // Alignment rule: half on 2, word on 4, doubleword on 8 bytes.
  always_comb begin
    w_misaligned = 1'b0;
    case (datatype)
      2'b01:   w_misaligned = Address[0];
      2'b10:   w_misaligned = |Address[1:0];
      2'b11:   w_misaligned = |Address[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end
`endif

  // First state after accepting a request: skip WAIT when no wait states,
  // jump straight to DONE on a rejected (misaligned) request.
  always_comb begin
    w_start_state = (WAIT_STATES == 0) ? S_BEAT0 : S_WAIT;
`ifdef MISALIGN_CHK_EN
    if (w_misaligned) w_start_state = S_DONE;
`endif
  end

  // Read formatting: narrow reads are right-justified, zero-extended.
  always_comb begin
    w_rd_word = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
    case (r_dtype)
      2'b00:   w_rd_data = {24'b0, r_mem[w_idx0]};
      2'b01:   w_rd_data = {16'b0, r_mem[w_idx0], r_mem[w_idx1]};
      default: w_rd_data = w_rd_word;
    endcase
  end

  // Array write port: contents survive reset, lowest address takes the MSB.
  always_ff @(posedge clk) begin
    if (w_we) begin
      case (r_dtype)
        2'b00: r_mem[w_idx0] <= w_wdata[7:0];
        2'b01: begin
          r_mem[w_idx0] <= w_wdata[15:8];
          r_mem[w_idx1] <= w_wdata[7:0];
        end
        default: begin
          r_mem[w_idx0] <= w_wdata[31:24];
          r_mem[w_idx1] <= w_wdata[23:16];
          r_mem[w_idx2] <= w_wdata[15:8];
          r_mem[w_idx3] <= w_wdata[7:0];
        end
      endcase
    end
  end

  // Handshake FSM with registered MOC, WordAck, DataOut (and Err).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rw    <= 1'b1;
      r_dtype <= 2'b00;
      r_addr  <= '0;
      r_din0  <= '0;
      r_din1  <= '0;
      r_beat1 <= 1'b0;
      r_cnt   <= '0;
      r_moc   <= 1'b0;
      r_ack   <= 1'b0;
      r_dout  <= '0;
`ifdef MISALIGN_CHK_EN
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MOV) begin
            r_rw    <= ReadWrite;
            r_dtype <= datatype;
            r_addr  <= Address[c_aw-1:0];
            r_din0  <= DataIn;
            r_beat1 <= 1'b0;
            r_cnt   <= '0;
            r_state <= w_start_state;
`ifdef MISALIGN_CHK_EN
            r_mis   <= w_misaligned;
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt == c_ws_last) begin
            r_cnt   <= '0;
            r_state <= r_beat1 ? S_BEAT1 : S_BEAT0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_BEAT0: begin
          if (r_rw) r_dout <= w_rd_data;
          r_state <= (r_dtype == 2'b11) ? S_ACK : S_DONE;
        end
        S_ACK: begin
          // Second write word is taken from the bus while the ack goes out.
          r_ack   <= 1'b1;
          r_din1  <= DataIn;
          r_beat1 <= 1'b1;
          r_state <= (WAIT_STATES == 0) ? S_BEAT1 : S_WAIT;
        end
        S_BEAT1: begin
          if (r_rw) r_dout <= w_rd_word;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle raises MOC; it then holds until MOV is low, so
          // a requester that already dropped MOV sees a one-cycle pulse.
          if (!r_moc) begin
            r_moc <= 1'b1;
`ifdef MISALIGN_CHK_EN
            r_err <= r_mis;
`endif
          end else if (!MOV) begin
            r_moc   <= 1'b0;
            r_state <= S_IDLE;
`ifdef MISALIGN_CHK_EN
            r_err   <= 1'b0;
            r_mis   <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DataOut = r_dout;
  assign WordAck = r_ack;
  assign MOC     = r_moc;
`ifdef MISALIGN_CHK_EN
  assign Err     = r_err;
`else
  assign Err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sync_hs
// Description : Directed self-checking bench for ram_sync_hs. Instance 0 runs
//               with no wait states, instance 1 with three wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sync_hs;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       mov = '0;
  logic [1:0]       rwv = '1;
  logic [1:0][1:0]  dtv = '0;
  logic [1:0][31:0] adr = '0;
  logic [1:0][31:0] din = '0;
  logic [1:0][31:0] dout;
  logic [1:0]       wack;
  logic [1:0]       moc;
  logic [1:0]       err;

  int          n_vec = 0;
  int          n_err = 0;
  int          lat;
  int          ack_at;
  int          ack_cnt;
  logic [31:0] ack_dout;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ram_sync_hs #(
      .DEPTH      (512),
      .ADDR_W     (32),
      .WAIT_STATES((gi == 0) ? 0 : 3)
    ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .MOV      (mov[gi]),
      .ReadWrite(rwv[gi]),
      .datatype (dtv[gi]),
      .Address  (adr[gi]),
      .DataIn   (din[gi]),
      .DataOut  (dout[gi]),
      .WordAck  (wack[gi]),
      .MOC      (moc[gi]),
      .Err      (err[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request: w0 is presented with MOV, w1 right after the sampling edge.
  // Counts edges after the sampling edge until MOC (bounded).
  task automatic op(input int d, input logic rw, input logic [1:0] dt, input logic [31:0] a,
                    input logic [31:0] w0, input logic [31:0] w1, input bit hold);
    @(negedge clk);
    mov[d] = 1'b1; rwv[d] = rw; dtv[d] = dt; adr[d] = a; din[d] = w0;
    @(posedge clk); #1;
    din[d] = w1;
    if (!hold) mov[d] = 1'b0;
    lat = 0; ack_at = 0; ack_cnt = 0; ack_dout = '0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (wack[d]) begin
        ack_cnt++;
        if (ack_at == 0) begin
          ack_at   = k;
          ack_dout = dout[d];
        end
      end
      if (moc[d]) begin
        lat = k;
        break;
      end
    end
  endtask

  // Held request: MOC must stay up while MOV is high, then clear after drop.
  task automatic release_op(input int d, input string tag);
    @(posedge clk); #1;
    check({tag, "_moc_hold"}, 32'(moc[d]), 32'd1);
    @(negedge clk);
    mov[d] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_moc_clr"}, 32'(moc[d]), 32'd0);
    check({tag, "_err_clr"}, 32'(err[d]), 32'd0);
  endtask

  task automatic rd(input int d, input logic [1:0] dt, input logic [31:0] a,
                    input logic [31:0] exp, input string tag);
    op(d, 1'b1, dt, a, 32'h0, 32'h0, 1'b1);
    check(tag, dout[d], exp);
    release_op(d, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_moc",  32'(moc[0]),  32'd0);
    check("rst_wack", 32'(wack[0]), 32'd0);
    check("rst_err",  32'(err[0]),  32'd0);
    check("rst_dout", dout[0],      32'h0);

    // Word write and read-back, no wait states.
    op(0, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b1);
    check("wr_word_lat", lat, 2);
    check("wr_keeps_dout", dout[0], 32'h0);
    release_op(0, "wr_word");
    op(0, 1'b1, 2'b10, 32'h10, 32'h0, 32'h0, 1'b1);
    check("rd_word_lat", lat, 2);
    check("rd_word", dout[0], 32'hDEADBEEF);
    release_op(0, "rd_word");
    rd(0, 2'b00, 32'h11, 32'h000000AD, "rd_byte_11");

    // Doubleword write then read-back.
    op(0, 1'b0, 2'b11, 32'h40, 32'h01234567, 32'h89ABCDEF, 1'b1);
    check("dw_wr_ack_at", ack_at, 2);
    check("dw_wr_ack_cnt", ack_cnt, 1);
    check("dw_wr_lat", lat, 4);
    release_op(0, "dw_wr");
    rd(0, 2'b00, 32'h40, 32'h00000001, "dw_b40");
    rd(0, 2'b00, 32'h43, 32'h00000067, "dw_b43");
    rd(0, 2'b00, 32'h44, 32'h00000089, "dw_b44");
    rd(0, 2'b00, 32'h47, 32'h000000EF, "dw_b47");
    rd(0, 2'b01, 32'h42, 32'h00004567, "dw_h42");
    op(0, 1'b1, 2'b11, 32'h40, 32'h0, 32'h0, 1'b1);
    check("dw_rd_ack_at", ack_at, 2);
    check("dw_rd_ack_cnt", ack_cnt, 1);
    check("dw_rd_word0", ack_dout, 32'h01234567);
    check("dw_rd_lat", lat, 4);
    check("dw_rd_word1", dout[0], 32'h89ABCDEF);
    release_op(0, "dw_rd");

`ifndef MISALIGN_CHK_EN
    // Unaligned word straddling the top of memory wraps to address 0.
    op(0, 1'b0, 2'b10, 32'd510, 32'hA1B2C3D4, 32'h0, 1'b1);
    check("wrap_err", 32'(err[0]), 32'd0);
    release_op(0, "wrap_wr");
    rd(0, 2'b00, 32'd510, 32'h000000A1, "wrap_b510");
    rd(0, 2'b00, 32'd511, 32'h000000B2, "wrap_b511");
    rd(0, 2'b00, 32'd0,   32'h000000C3, "wrap_b0");
    rd(0, 2'b00, 32'd1,   32'h000000D4, "wrap_b1");
    rd(0, 2'b10, 32'd510, 32'hA1B2C3D4, "wrap_word");
`endif

    // Three wait states: half, then doubleword through the WAIT path twice.
    op(1, 1'b0, 2'b01, 32'h20, 32'hFFFF1234, 32'h0, 1'b1);
    check("ws3_wr_half_lat", lat, 5);
    release_op(1, "ws3_wr_half");
    op(1, 1'b1, 2'b01, 32'h20, 32'h0, 32'h0, 1'b1);
    check("ws3_rd_half_lat", lat, 5);
    check("ws3_rd_half", dout[1], 32'h00001234);
    release_op(1, "ws3_rd_half");
    op(1, 1'b0, 2'b11, 32'h48, 32'hCAFEBABE, 32'h13579BDF, 1'b1);
    check("ws3_dw_ack_at", ack_at, 5);
    check("ws3_dw_lat", lat, 10);
    release_op(1, "ws3_dw_wr");
    op(1, 1'b1, 2'b11, 32'h48, 32'h0, 32'h0, 1'b1);
    check("ws3_dw_word0", ack_dout, 32'hCAFEBABE);
    check("ws3_dw_rd_lat", lat, 10);
    check("ws3_dw_word1", dout[1], 32'h13579BDF);
    release_op(1, "ws3_dw_rd");

    // MOV dropped right after being sampled: op completes, MOC pulses once.
    op(0, 1'b1, 2'b10, 32'h10, 32'h0, 32'h0, 1'b0);
    check("drop_lat", lat, 2);
    check("drop_dout", dout[0], 32'hDEADBEEF);
    @(posedge clk); #1;
    check("drop_pulse", 32'(moc[0]), 32'd0);

`ifdef MISALIGN_CHK_EN
    op(0, 1'b1, 2'b10, 32'h13, 32'h0, 32'h0, 1'b1);
    check("mis_lat", lat, 1);
    check("mis_err", 32'(err[0]), 32'd1);
    check("mis_dout", dout[0], 32'hDEADBEEF);
    check("mis_no_ack", ack_cnt, 0);
    release_op(0, "mis");
    op(0, 1'b0, 2'b01, 32'h21, 32'h0000FFFF, 32'h0, 1'b0);
    check("mis_drop_lat", lat, 1);
    check("mis_drop_err", 32'(err[0]), 32'd1);
    @(posedge clk); #1;
    check("mis_drop_pulse", 32'(moc[0]), 32'd0);
    check("mis_drop_err_clr", 32'(err[0]), 32'd0);
`endif

    // Reset in the middle of doubleword beat 1: first word stays written.
    op(0, 1'b0, 2'b10, 32'h84, 32'hCAFEF00D, 32'h0, 1'b1);
    release_op(0, "pre_rst_wr");
    @(negedge clk);
    mov[0] = 1'b1; rwv[0] = 1'b0; dtv[0] = 2'b11; adr[0] = 32'h80; din[0] = 32'h11223344;
    @(posedge clk); #1;
    din[0] = 32'h55667788;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_ack_seen", 32'(wack[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_moc",  32'(moc[0]),  32'd0);
    check("rst_mid_wack", 32'(wack[0]), 32'd0);
    check("rst_mid_dout", dout[0],      32'h0);
    mov[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd(0, 2'b10, 32'h80, 32'h11223344, "rst_word0_kept");
    rd(0, 2'b10, 32'h84, 32'hCAFEF00D, "rst_word1_untouched");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
